// File: rtl/program_memory_pkg.sv
// Shared definitions for program_memory: loader states, NOP encoding and boot image.
// PROG_MEM_BOOT_EN selects whether the boot image is live out of reset.
package program_memory_pkg;

  typedef enum logic {
    LD_IDLE    = 1'b0,
    LD_COLLECT = 1'b1
  } ld_state_t;

  localparam logic [31:0] PM_NOP = 32'h0000_0000;

  // MOV instruction field encodings
  localparam logic [5:0] OP_MOV   = 6'h01;
  localparam logic [1:0] MODE_PUR = 2'b00;
  localparam logic [1:0] SRC_NUM  = 2'b01;
  localparam logic [1:0] DST_REG  = 2'b10;
  localparam logic [3:0] REG_DOUT = 4'hf;
  localparam logic [3:0] WID_N8   = 4'h8;

  localparam int BOOT_LEN = 10;

`ifdef PROG_MEM_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  // Boot word idx = MOV PUR NUM k REG DOUT N8 with k = 2*idx+1
  function automatic logic [31:0] boot_word(input logic [3:0] idx);
    logic [11:0] k;
    k = {7'd0, idx, 1'b1};
    return {OP_MOV, MODE_PUR, SRC_NUM, DST_REG, REG_DOUT, WID_N8, k};
  endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-serial program loader: assembles MSB-first bytes into words and
// drives the array write port. Reset length depends on PROG_MEM_BOOT_EN.
module program_loader
  import program_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);
  localparam int BPW   = DATA_WIDTH / 8;
  localparam int CW    = $clog2(BPW) + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0]       LAST_BYTE = CW'(BPW - 1);
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LEN_RST   = BOOT_EN ? (ADDR_WIDTH + 1)'(BOOT_LEN) : '0;

  ld_state_t             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_upd;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LD_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      len_q   <= LEN_RST;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // The write pointer is the current length: every completed word appends.
  assign wr_addr    = len_q[ADDR_WIDTH-1:0];
  assign wr_data    = (asm_q << 8) | DATA_WIDTH'(load_byte);
  assign load_ready = (state_q == LD_COLLECT);
  assign load_busy  = (state_q == LD_COLLECT);
  assign load_done  = done_q;
  assign load_error = err_q;
  assign prog_len   = len_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_upd = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    err_d   = err_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (load_start) begin
          state_d = LD_COLLECT;
          cnt_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
        end
      end
      LD_COLLECT: begin
        if (load_start) begin
          // Restart: the partial word is dropped silently.
          cnt_d = '0;
          len_d = '0;
          err_d = 1'b0;
        end else begin
          if (load_byte_valid) begin
            asm_d = wr_data;
            if (cnt_q == LAST_BYTE) begin
              wr_en   = 1'b1;
              len_d   = len_q + 1'b1;
              cnt_upd = '0;
              if (len_q == LAST_WORD) begin
                state_d = LD_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              cnt_upd = cnt_q + 1'b1;
            end
          end
          cnt_d = cnt_upd;
          // Termination sees the count after this cycle's byte.
          if (load_end && state_d == LD_COLLECT) begin
            state_d = LD_IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            if (cnt_upd != '0) err_d = 1'b1;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

endmodule

// File: rtl/program_memory.sv
// Instruction store with one-cycle registered fetch and a run-time byte loader.
// PROG_MEM_BOOT_EN makes the boot image visible out of reset.
module program_memory
  import program_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(PM_NOP)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] instruction,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   prog_len
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] BOOT_LEN_W = (ADDR_WIDTH + 1)'(BOOT_LEN);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  boot_q;
  logic                  accept;

  program_loader #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_loader (
    .clock          (clock),
    .reset          (reset),
    .load_start     (load_start),
    .load_end       (load_end),
    .load_byte_valid(load_byte_valid),
    .load_byte      (load_byte),
    .load_ready     (load_ready),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_error     (load_error),
    .prog_len       (prog_len),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data)
  );

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Boot image overlays the array until the first load starts; a reset
  // re-arms it since prog_len returns to the boot length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           boot_q <= BOOT_EN;
    else if (load_start) boot_q <= 1'b0;
  end

  always_comb begin
    rd_word = NOP_WORD;
    if ({1'b0, fetch_addr} < prog_len) begin
      if (boot_q && ({1'b0, fetch_addr} < BOOT_LEN_W))
        rd_word = DATA_WIDTH'(boot_word(4'(fetch_addr)));
      else
        rd_word = mem[fetch_addr];
    end
  end

  // Writes only happen while busy, and busy blocks fetches: no RAW hazard.
  assign accept = fetch_req && !load_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_valid <= 1'b0;
      instruction <= NOP_WORD;
    end else begin
      fetch_valid <= accept;
      if (accept) instruction <= rd_word;
    end
  end

endmodule
